// File: rtl/snake_pkg.sv
// Shared playfield bounds, reward type encoding and scheduler state encoding.
package snake_pkg;

  localparam int unsigned X_MIN = 4;
  localparam int unsigned X_MAX = 19;
  localparam int unsigned Y_MIN = 2;
  localparam int unsigned Y_MAX = 9;

  localparam logic [7:0] LFSR_SEED = 8'h5A;
  // Right-shifting Galois form of x^8 + x^6 + x^5 + x^4 + 1
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    RW_NONE = 2'd0,
    RW_T1   = 2'd1,
    RW_T2   = 2'd2,
    RW_T3   = 2'd3
  } rw_type_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DRAW,
    S_QUERY,
    S_SHOW
  } rs_state_e;

  function automatic rw_type_e draw_type(input logic [7:0] r);
    if (r <= 8'd100) return RW_T1;
    if (r <= 8'd200) return RW_T2;
    return RW_T3;
  endfunction

endpackage

// File: rtl/reward_lfsr8.sv
// Free-running 8-bit Galois LFSR; the seed must be non-zero.
module reward_lfsr8
  import snake_pkg::*;
#(
  parameter logic [7:0] SEED = LFSR_SEED
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);

  logic [7:0] q_q, q_d;

  always_comb begin
    q_d = q_q >> 1;
    if (q_q[0]) q_d = q_d ^ LFSR_TAPS;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= SEED;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/reward_spawn_scheduler.sv
// Reward placement sequencer: random delay, candidate draw, occupancy query, display.
module reward_spawn_scheduler
  import snake_pkg::*;
#(
  parameter int unsigned BASE_TICKS = 20,
  parameter int unsigned STAY_TICKS = 40,
  parameter int unsigned MAX_RETRY  = 8,
  parameter int unsigned X_OFF      = X_MIN,
  parameter int unsigned Y_OFF      = Y_MIN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       enable,
  input  logic       clear,
  output logic       occ_req,
  output logic [5:0] occ_x,
  output logic [5:0] occ_y,
  input  logic       occ_ack,
  input  logic       occ_hit,
  input  logic       eaten,
  output logic       reward_valid,
  output logic [5:0] reward_x,
  output logic [5:0] reward_y,
  output logic [1:0] reward_type,
  output logic       place_fail
);

  localparam logic [8:0] BASE_W    = 9'(BASE_TICKS);
  localparam logic [7:0] STAY_LAST = 8'(STAY_TICKS - 1);
  localparam logic [3:0] RETRY_W   = 4'(MAX_RETRY);
  localparam logic [5:0] XOFF_W    = 6'(X_OFF);
  localparam logic [5:0] YOFF_W    = 6'(Y_OFF);

  logic [7:0] lfsr;

  reward_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  rs_state_e  state_q, state_d;
  logic [8:0] delay_q, delay_d;
  logic [8:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] stay_cnt_q, stay_cnt_d;
  logic [3:0] retry_q, retry_d;
  logic [5:0] cand_x_q, cand_x_d;
  logic [5:0] cand_y_q, cand_y_d;
  rw_type_e   cand_type_q, cand_type_d;
  logic       occ_req_q, occ_req_d;
  logic       rw_valid_q, rw_valid_d;
  logic [5:0] rw_x_q, rw_x_d;
  logic [5:0] rw_y_q, rw_y_d;
  rw_type_e   rw_type_q, rw_type_d;
  logic       fail_q, fail_d;

  logic tick_en;
  assign tick_en = tick & enable;

  always_comb begin
    state_d     = state_q;
    delay_d     = delay_q;
    wait_cnt_d  = wait_cnt_q;
    stay_cnt_d  = stay_cnt_q;
    retry_d     = retry_q;
    cand_x_d    = cand_x_q;
    cand_y_d    = cand_y_q;
    cand_type_d = cand_type_q;
    occ_req_d   = occ_req_q;
    rw_valid_d  = rw_valid_q;
    rw_x_d      = rw_x_q;
    rw_y_d      = rw_y_q;
    rw_type_d   = rw_type_q;
    fail_d      = 1'b0;

    if (clear) begin
      // Abandons any in-flight occupancy query as well as a shown reward
      state_d     = S_IDLE;
      delay_d     = '0;
      wait_cnt_d  = '0;
      stay_cnt_d  = '0;
      retry_d     = '0;
      cand_x_d    = '0;
      cand_y_d    = '0;
      cand_type_d = RW_NONE;
      occ_req_d   = 1'b0;
      rw_valid_d  = 1'b0;
      rw_x_d      = '0;
      rw_y_d      = '0;
      rw_type_d   = RW_NONE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (enable) begin
            state_d    = S_WAIT;
            delay_d    = BASE_W + {2'b00, lfsr[7:1]};
            wait_cnt_d = '0;
            retry_d    = '0;
          end
        end
        S_WAIT: begin
          if (wait_cnt_q == delay_q) state_d = S_DRAW;
          else if (tick_en)          wait_cnt_d = wait_cnt_q + 9'd1;
        end
        S_DRAW: begin
          cand_x_d    = {2'b00, lfsr[3:0]} + XOFF_W;
          cand_y_d    = {3'b000, lfsr[6:4]} + YOFF_W;
          cand_type_d = draw_type(lfsr);
          occ_req_d   = 1'b1;
          state_d     = S_QUERY;
        end
        S_QUERY: begin
          if (occ_ack) begin
            occ_req_d = 1'b0;
            if (!occ_hit) begin
              state_d    = S_SHOW;
              stay_cnt_d = '0;
              rw_valid_d = 1'b1;
              rw_x_d     = cand_x_q;
              rw_y_d     = cand_y_q;
              rw_type_d  = cand_type_q;
            end else if (retry_q + 4'd1 == RETRY_W) begin
              state_d = S_IDLE;
              retry_d = '0;
              fail_d  = 1'b1;
            end else begin
              state_d = S_DRAW;
              retry_d = retry_q + 4'd1;
            end
          end
        end
        S_SHOW: begin
          // Eaten and expiry on the same tick collapse into this one exit
          if (eaten || (tick_en && stay_cnt_q == STAY_LAST)) begin
            state_d    = S_IDLE;
            rw_valid_d = 1'b0;
            rw_x_d     = '0;
            rw_y_d     = '0;
            rw_type_d  = RW_NONE;
          end else if (tick_en) begin
            stay_cnt_d = stay_cnt_q + 8'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      delay_q     <= '0;
      wait_cnt_q  <= '0;
      stay_cnt_q  <= '0;
      retry_q     <= '0;
      cand_x_q    <= '0;
      cand_y_q    <= '0;
      cand_type_q <= RW_NONE;
      occ_req_q   <= 1'b0;
      rw_valid_q  <= 1'b0;
      rw_x_q      <= '0;
      rw_y_q      <= '0;
      rw_type_q   <= RW_NONE;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      delay_q     <= delay_d;
      wait_cnt_q  <= wait_cnt_d;
      stay_cnt_q  <= stay_cnt_d;
      retry_q     <= retry_d;
      cand_x_q    <= cand_x_d;
      cand_y_q    <= cand_y_d;
      cand_type_q <= cand_type_d;
      occ_req_q   <= occ_req_d;
      rw_valid_q  <= rw_valid_d;
      rw_x_q      <= rw_x_d;
      rw_y_q      <= rw_y_d;
      rw_type_q   <= rw_type_d;
      fail_q      <= fail_d;
    end
  end

  assign occ_req      = occ_req_q;
  assign occ_x        = cand_x_q;
  assign occ_y        = cand_y_q;
  assign reward_valid = rw_valid_q;
  assign reward_x     = rw_x_q;
  assign reward_y     = rw_y_q;
  assign reward_type  = rw_type_q;
  assign place_fail   = fail_q;

endmodule

// File: tb/tb_reward_spawn_scheduler.sv
// Directed bench for reward_spawn_scheduler; LFSR snapshots are pinned with force.
module tb_reward_spawn_scheduler;
  import snake_pkg::*;

  logic       clk = 1'b0;
  logic       rst, tick, enable, clear;
  logic       occ_req, occ_ack, occ_hit, eaten;
  logic [5:0] occ_x, occ_y, reward_x, reward_y;
  logic       reward_valid, place_fail;
  logic [1:0] reward_type;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  reward_spawn_scheduler #(
    .BASE_TICKS (20),
    .STAY_TICKS (40),
    .MAX_RETRY  (8),
    .X_OFF      (4),
    .Y_OFF      (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .enable       (enable),
    .clear        (clear),
    .occ_req      (occ_req),
    .occ_x        (occ_x),
    .occ_y        (occ_y),
    .occ_ack      (occ_ack),
    .occ_hit      (occ_hit),
    .eaten        (eaten),
    .reward_valid (reward_valid),
    .reward_x     (reward_x),
    .reward_y     (reward_y),
    .reward_type  (reward_type),
    .place_fail   (place_fail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_req(input string tag);
    int unsigned n = 0;
    while (occ_req !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(occ_req), 32'd1);
  endtask

  task automatic ack(input logic hit);
    occ_ack = 1'b1;
    occ_hit = hit;
    @(negedge clk);
    occ_ack = 1'b0;
    occ_hit = 1'b0;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({occ_req, reward_valid, place_fail, reward_x, reward_y,
                reward_type, occ_x, occ_y});
  endfunction

  initial begin
    rst = 1'b1; tick = 1'b0; enable = 1'b0; clear = 1'b0;
    occ_ack = 1'b0; occ_hit = 1'b0; eaten = 1'b0;

    // Reset values and free-running LFSR
    @(negedge clk);
    chk("rst_outs", all_outs(), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(S_IDLE));
    chk("rst_lfsr", 32'(dut.lfsr), 32'h5A);
    rst = 1'b0;
    @(negedge clk);
    chk("lfsr_step1", 32'(dut.lfsr), 32'h2D);
    @(negedge clk);
    chk("lfsr_step2", 32'(dut.lfsr), 32'hAE);
    chk("idle_no_enable", 32'(dut.state_q), 32'(S_IDLE));

    // 1: snapshot 0x10 -> 28-tick wait
    force dut.lfsr = 8'h10;
    enable = 1'b1;
    @(negedge clk);
    chk("t1_wait", 32'(dut.state_q), 32'(S_WAIT));
    chk("t1_delay", 32'(dut.delay_q), 32'd28);
    force dut.lfsr = 8'h37;
    repeat (27) tick_pulse();
    chk("t1_still_wait", 32'(dut.state_q), 32'(S_WAIT));
    chk("t1_no_req_27", 32'(occ_req), 32'd0);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("t1_no_req_28", 32'(occ_req), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("t1_req_2clk", 32'(occ_req), 32'd1);

    // 2: snapshot 0x37, clean cell; handshake completes even with enable low
    chk("t2_occ_x", 32'(occ_x), 32'd11);
    chk("t2_occ_y", 32'(occ_y), 32'd5);
    enable = 1'b0;
    ack(1'b0);
    enable = 1'b1;
    chk("t2_valid", 32'(reward_valid), 32'd1);
    chk("t2_rx", 32'(reward_x), 32'd11);
    chk("t2_ry", 32'(reward_y), 32'd5);
    chk("t2_type", 32'(reward_type), 32'(RW_T1));
    chk("t2_req_drop", 32'(occ_req), 32'd0);

    // 3: expiry after exactly 40 ticks
    force dut.lfsr = 8'h00;
    repeat (39) tick_pulse();
    chk("t3_valid_39", 32'(reward_valid), 32'd1);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("t3_valid_40", 32'(reward_valid), 32'd0);
    chk("t3_outs_zero", 32'({reward_x, reward_y, reward_type}), 32'd0);
    chk("t3_idle", 32'(dut.state_q), 32'(S_IDLE));

    // 4: eight occupied candidates -> one place_fail pulse
    @(negedge clk);
    chk("t4_wait", 32'(dut.state_q), 32'(S_WAIT));
    force dut.lfsr = 8'hFF;
    repeat (20) tick_pulse();
    for (int i = 0; i < 8; i++) begin
      wait_req("t4_req");
      if (i == 0) begin
        chk("t4_occ_x_max", 32'(occ_x), 32'(X_MAX));
        chk("t4_occ_y_max", 32'(occ_y), 32'(Y_MAX));
      end
      if (i == 7) force dut.lfsr = 8'h00;
      ack(1'b1);
      chk("t4_fail", 32'(place_fail), (i == 7) ? 32'd1 : 32'd0);
    end
    chk("t4_idle", 32'(dut.state_q), 32'(S_IDLE));
    chk("t4_no_valid", 32'(reward_valid), 32'd0);
    @(negedge clk);
    chk("t4_fail_pulse", 32'(place_fail), 32'd0);
    chk("t4_rearm", 32'(dut.state_q), 32'(S_WAIT));

    // 5a: eaten on the expiry tick -> single exit
    force dut.lfsr = 8'hC8;
    repeat (20) tick_pulse();
    wait_req("t5a_req");
    chk("t5a_occ_x", 32'(occ_x), 32'd12);
    chk("t5a_occ_y", 32'(occ_y), 32'd6);
    ack(1'b0);
    chk("t5a_valid", 32'(reward_valid), 32'd1);
    chk("t5a_type", 32'(reward_type), 32'(RW_T2));
    force dut.lfsr = 8'h00;
    repeat (39) tick_pulse();
    tick = 1'b1;
    eaten = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    eaten = 1'b0;
    chk("t5a_exit", 32'(reward_valid), 32'd0);
    chk("t5a_idle", 32'(dut.state_q), 32'(S_IDLE));
    chk("t5a_no_fail", 32'(place_fail), 32'd0);
    @(negedge clk);
    chk("t5a_rearm", 32'(dut.state_q), 32'(S_WAIT));

    // 5b: eaten outside SHOW ignored; clear mid-query abandons handshake
    eaten = 1'b1;
    @(negedge clk);
    eaten = 1'b0;
    chk("t5b_eaten_ignored", 32'(dut.state_q), 32'(S_WAIT));
    repeat (20) tick_pulse();
    wait_req("t5b_req");
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("t5b_req_drop", 32'(occ_req), 32'd0);
    chk("t5b_idle", 32'(dut.state_q), 32'(S_IDLE));
    ack(1'b0);
    chk("t5b_ack_ignored", 32'(reward_valid), 32'd0);
    chk("t5b_no_req", 32'(occ_req), 32'd0);
    force dut.lfsr = 8'hC9;

    // 6: enable low for 10 ticks in SHOW extends the lifetime
    repeat (20) tick_pulse();
    wait_req("t6_req");
    chk("t6_occ_x", 32'(occ_x), 32'd13);
    chk("t6_occ_y", 32'(occ_y), 32'd6);
    ack(1'b0);
    chk("t6_type", 32'(reward_type), 32'(RW_T3));
    force dut.lfsr = 8'h00;
    repeat (20) tick_pulse();
    enable = 1'b0;
    repeat (10) tick_pulse();
    enable = 1'b1;
    chk("t6_frozen_show", 32'(dut.state_q), 32'(S_SHOW));
    repeat (19) tick_pulse();
    chk("t6_extended", 32'(reward_valid), 32'd1);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("t6_expired", 32'(reward_valid), 32'd0);

    // 6: asynchronous reset mid-SHOW
    @(negedge clk);
    repeat (20) tick_pulse();
    wait_req("t6r_req");
    ack(1'b0);
    chk("t6r_valid", 32'(reward_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6r_async_outs", all_outs(), 32'd0);
    chk("t6r_async_state", 32'(dut.state_q), 32'(S_IDLE));
    release dut.lfsr;
    #1;
    chk("t6r_lfsr_seed", 32'(dut.lfsr), 32'h5A);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
